// File: rtl/data_memory_ws_pkg.sv
// data_memory_ws_pkg -- shared definitions for the wait-state data memory.
//   state_e       : request FSM states (IDLE, WAIT, RESP)
//   DMEM_PRELOAD  : initial image for words 0..14, used only when the
//                   DATA_MEMORY_WS_PRELOAD_EN macro is defined
//   addr_err()    : misaligned / out-of-range byte address check
package data_memory_ws_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DMEM_PRELOAD_N = 15;

  localparam logic [31:0] DMEM_PRELOAD [DMEM_PRELOAD_N] = '{
    32'hA01100AB, 32'h10101011, 32'h00000000, 32'hFFFFFFFF,
    32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0,
    32'h00C0FFEE, 32'hCAFEBABE, 32'h55AA55AA, 32'hAA55AA55,
    32'h01020304, 32'h80000001, 32'h921101BB
  };

  // An access is in error when it is not word aligned or addresses past the
  // last word. The limit is computed in 34 bits so depth*4 cannot wrap.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- word-organised storage with byte-lane writes and a
// combinational read port.
// Build option: DATA_MEMORY_WS_PRELOAD_EN loads words 0..14 from
// DMEM_PRELOAD; without it the array starts uninitialised.
// Ports:
//   clk      in  clock, writes on rising edge
//   we_i     in  write enable for this cycle
//   idx_i    in  word index (read and write)
//   wdata_i  in  write data
//   be_i     in  byte-lane enables for the write
//   rdata_o  out word at idx_i (combinational)
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [NB-1:0]     be_i,
  output logic [DATA_W-1:0] rdata_o
);
  import data_memory_ws_pkg::*;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

`ifdef DATA_MEMORY_WS_PRELOAD_EN
  function automatic mem_t preload_image();
    mem_t img;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      img[i] = (i < DMEM_PRELOAD_N) ? DATA_W'(DMEM_PRELOAD[i]) : '0;
    end
    return img;
  endfunction

  mem_t mem_q = preload_image();
`else
  mem_t mem_q;
`endif

  // NOTE: the storage array has no reset; clearing it would need a write
  // port per word and a reset must leave the contents intact anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_memory_ws.sv
// data_memory_ws -- single-port data memory with a configurable number of
// wait states and a valid/ready request/response handshake. One request
// may be outstanding; the access happens on the edge that enters RESP.
// Build option: DATA_MEMORY_WS_PRELOAD_EN (see dmem_array).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_write         1 = write, 0 = read
//   req_addr          byte address (word aligned, below DEPTH*4)
//   req_wdata/req_be  write data and byte-lane enables
//   resp_valid/ready  response handshake, response held until taken
//   resp_rdata        read data; 0 for writes and errored accesses
//   resp_err          misaligned or out-of-range access
module data_memory_ws #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned NB         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  import data_memory_ws_pkg::*;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                wr_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       be_q;

  logic                accept;
  logic                do_access;
  logic                acc_wr, acc_err, mem_we;
  logic [31:0]         acc_addr;
  logic [DATA_W-1:0]   acc_wdata, mem_rdata;
  logic [NB-1:0]       acc_be;

  assign accept = req_valid && (state_q == IDLE);

  // With no wait states the access happens on the accept edge itself, so
  // the live request feeds the array; otherwise the latched copy does.
  assign acc_wr    = (state_q == IDLE) ? req_write : wr_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? req_be    : be_q;
  assign acc_err   = addr_err(acc_addr, DEPTH);

  assign do_access = (state_q == IDLE) ? (accept && (WAIT_STATES == 0))
                                       : ((state_q == WAIT) && (cnt_q == 3'd0));

  // A reset edge must not commit a pending write, even one whose count
  // expires on that same edge.
  assign mem_we = rst_n && do_access && acc_wr && !acc_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .idx_i   (acc_addr[AW+1:2]),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (mem_rdata)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d takes a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  // Wait counter and response payload.
  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept && (WAIT_STATES > 0)) begin
      cnt_d = 3'(WAIT_STATES - 1);
    end else if ((state_q == WAIT) && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_wr || acc_err) ? '0 : mem_rdata;
    end else if ((state_q == RESP) && resp_ready) begin
      err_d   = 1'b0;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture; only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws -- directed bench for data_memory_ws with two instances:
// index 0 has no wait states, index 1 has three. Expected responses come
// from a reference memory model and are queued when a request is driven.
module tb_data_memory_ws;

  localparam int WS [2] = '{0, 3};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] model [2][256];
  exp_t        sb_q [$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  data_memory_ws #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_memory_ws #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance s. The expected response is
  // computed from the model and queued before the request is driven.
  task automatic txn(input int s, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input bit stall, input string tag);
    exp_t  e;
    exp_t  got;
    int    lat;
    string t;
    t       = $sformatf("%s/ws%0d", tag, WS[s]);
    e.err   = (a[1:0] != 2'b00) || (a >= 32'h400);
    e.rdata = '0;
    e.lat   = WS[s] + 1;
    if (!e.err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[s][a[9:2]][b*8 +: 8] = wd[b*8 +: 8];
        end
      end else begin
        e.rdata = model[s][a[9:2]];
      end
    end
    sb_q.push_back(e);

    @(negedge clk);
    check({t, "/req_ready_idle"}, 32'(req_ready[s]), 32'd1);
    req_valid[s]  = 1'b1;
    req_write[s]  = wr;
    req_addr[s]   = a;
    req_wdata[s]  = wd;
    req_be[s]     = be;
    resp_ready[s] = !stall;
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    lat = 1;
    while (!resp_valid[s] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = sb_q.pop_front();
    if (!resp_valid[s]) begin
      check({t, "/resp_timeout"}, 32'd0, 32'd1);
    end else begin
      check({t, "/latency"}, 32'(lat), 32'(got.lat));
      check({t, "/rdata"}, resp_rdata[s], got.rdata);
      check({t, "/err"}, 32'(resp_err[s]), 32'(got.err));
    end
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({t, "/stall_valid"}, 32'(resp_valid[s]), 32'd1);
        check({t, "/stall_rdata"}, resp_rdata[s], got.rdata);
        check({t, "/stall_req_ready"}, 32'(req_ready[s]), 32'd0);
      end
      resp_ready[s] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready[s] = 1'b0;
    check({t, "/post_valid"}, 32'(resp_valid[s]), 32'd0);
    check({t, "/post_req_ready"}, 32'(req_ready[s]), 32'd1);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s]      = 1'b0;
      req_valid[s]  = 1'b0;
      req_write[s]  = 1'b0;
      req_addr[s]   = '0;
      req_wdata[s]  = '0;
      req_be[s]     = '0;
      resp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b1;
      check($sformatf("reset_req_ready/%0d", s), 32'(req_ready[s]), 32'd1);
      check($sformatf("reset_resp_valid/%0d", s), 32'(resp_valid[s]), 32'd0);
      check($sformatf("reset_rdata/%0d", s), resp_rdata[s], 32'd0);
      check($sformatf("reset_err/%0d", s), 32'(resp_err[s]), 32'd0);
    end

    // Zero wait states: write then read back.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr10");
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, "rd10");
    // Byte-lane merge.
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, "wr20_full");
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, "wr20_lanes");
    txn(0, 1'b0, 32'h20, 32'h0,        4'h0, 1'b0, "rd20_merge");
    // Error cases: misaligned, out of range, errored write leaves word 0.
    txn(0, 1'b1, 32'h0,   32'h01020304, 4'hF, 1'b0, "wr0");
    txn(0, 1'b0, 32'h13,  32'h0,        4'h0, 1'b0, "rd_misaligned");
    txn(0, 1'b0, 32'h400, 32'h0,        4'h0, 1'b0, "rd_out_of_range");
    txn(0, 1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, 1'b0, "wr_err");
    txn(0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, "rd0_unchanged");
    // be=0 write is a no-op without error.
    txn(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 1'b0, "wr_be0");
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, "rd10_after_be0");
    // Back-pressure on the response.
    txn(0, 1'b0, 32'h20, 32'h0,        4'h0, 1'b1, "rd20_stall");

    // Three wait states.
    txn(1, 1'b1, 32'h8,   32'h0BADF00D, 4'hF, 1'b0, "wr8");
    txn(1, 1'b0, 32'h8,   32'h0,        4'h0, 1'b0, "rd8");
    txn(1, 1'b0, 32'h3FC, 32'h0,        4'h0, 1'b0, "rd_last_unwritten_err_free");
    txn(1, 1'b0, 32'h13,  32'h0,        4'h0, 1'b1, "rd_misaligned_stall");

    // Reset two cycles after accepting a write: the write and its response
    // are dropped and the old word survives.
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_write[1]  = 1'b1;
    req_addr[1]   = 32'h8;
    req_wdata[1]  = 32'h55555555;
    req_be[1]     = 4'hF;
    resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    check("rst_wait/req_ready", 32'(req_ready[1]), 32'd1);
    check("rst_wait/rdata", resp_rdata[1], 32'd0);
    check("rst_wait/err", 32'(resp_err[1]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("rst_wait/no_resp", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
    end
    resp_ready[1] = 1'b0;
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, "rd8_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, number of words (power of two).
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra access cycles, range 0..7.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted when valid and ready both high at a rising edge.
REQ-008 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  DATA_W  write data.
REQ-011 SHALL have port req_be  in  DATA_W/8  byte-lane write enables.
REQ-012 SHALL have port resp_valid  out  1  response present.
REQ-013 SHALL have port resp_ready  in  1  response consumed when valid and ready both high.
REQ-014 SHALL have port resp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-015 SHALL have port resp_err  out  1  misaligned or out-of-range access.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; one outstanding request maximum.
REQ-018 IDLE on accept: latch write, addr, wdata, be; go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else perform access and go to RESP.
REQ-019 WAIT: decrement counter each cycle; at counter 0, perform access and go to RESP.
REQ-020 resp_valid SHALL rise exactly WAIT_STATES+1 cycles after the accept edge.
REQ-021 RESP: hold resp_valid, resp_rdata, resp_err stable until resp_ready=1; then go to IDLE (req_ready=1 next cycle).
REQ-022 Word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-023 Error SHALL be raised when req_addr[1:0]!=0 or req_addr>=DEPTH*4; errored access changes no memory and returns rdata=0.
REQ-024 Write SHALL update only lanes with req_be bit set; be=0 write is a legal no-op with resp_err=0.
REQ-025 Access SHALL be performed at the edge entering RESP; a read accepted after a write's response sees the written data.

Reset
REQ-026 rst_n low at a rising edge SHALL force IDLE, req_ready=1 next cycle, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-027 Reset during WAIT SHALL discard the pending write; reset during RESP SHALL drop the response; memory contents SHALL NOT be cleared.

Configuration
REQ-028 Macro DATA_MEMORY_WS_PRELOAD_EN defined: words 0..14 SHALL initialise from package table DMEM_PRELOAD (word0=32'hA01100AB, word1=32'h10101011, word14=32'h921101BB, rest per table).
REQ-029 Macro undefined: memory SHALL have no initial contents (X in simulation); all other behaviour identical.

Structure
REQ-030 Package data_memory_ws_pkg SHALL hold FSM state enum, DMEM_PRELOAD table, error-check helper function.
REQ-031 Storage SHALL be sub-module dmem_array (byte-lane write, combinational read); FSM and checks in top.

Verification
REQ-032 WAIT_STATES=0: write addr 0x10 data 0xDEADBEEF be=4'hF, then read 0x10 -> resp_valid 1 cycle after accept, rdata=0xDEADBEEF, err=0.
REQ-033 WAIT_STATES=3: read 0x0 with PRELOAD_EN -> resp_valid exactly 4 cycles after accept, rdata=0xA01100AB.
REQ-034 Write 0x20 0x11223344 be=4'hF, write 0x20 0xAABBCCDD be=4'b0101, read 0x20 -> rdata=0x11BB33DD.
REQ-035 Read 0x13 and read 0x400 (DEPTH=256) -> resp_err=1, rdata=0; write 0x402 -> err=1, memory unchanged.
REQ-036 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready=0 throughout; req_ready=1 cycle after handshake.
REQ-037 WAIT_STATES=4, rst_n low 2 cycles after write accept to 0x8 -> subsequent read 0x8 returns prior value.
